// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM stream reader.
// Holds the reader state encoding, the ROM image (address/data pairs),
// the fill value for unlisted addresses and the output buffer depth.
package rom_stream_pkg;

    // Reader control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // ROM image: ROM_ADDR[i] holds ROM_DATA[i]; everything else is the fill value
    localparam int unsigned ROM_ENTRIES = 6;
    localparam int unsigned ROM_ADDR [ROM_ENTRIES] = '{0, 1, 2, 3, 4, 6};
    localparam int unsigned ROM_DATA [ROM_ENTRIES] = '{3, 2, 1, 0, 4, 5};

    // Every bit of DEFAULT_DATA takes this value (all ones)
    localparam logic DEFAULT_FILL = 1'b1;

    // Output buffer depth, also the read credit limit
    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_sync.sv
// Registered-output table ROM with one cycle of read latency.
// Ports:
//   clk_i, reset_i : clock and synchronous active-high reset
//   en_i           : read strobe; data_o updates on the next edge only when set
//   addr_i         : read address
//   data_o         : registered ROM word
import rom_stream_pkg::*;

module rom_sync #(
    parameter int unsigned           ADDR_WIDTH   = 12,
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = {DATA_WIDTH{DEFAULT_FILL}}
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] lookup_c;
    logic [DATA_WIDTH-1:0] data_q;

    // Table lookup; unlisted addresses fall through to the fill value
    always_comb begin
        lookup_c = DEFAULT_DATA;
        for (int unsigned i = 0; i < ROM_ENTRIES; i++) begin
            if (addr_i == ADDR_WIDTH'(ROM_ADDR[i])) begin
                lookup_c = DATA_WIDTH'(ROM_DATA[i]);
            end
        end
    end

    // Output register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= lookup_c;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Burst reader: accepts {addr, len, dir} commands and streams ROM words out
// over a valid/ready interface with a 2-entry output buffer and credit-based
// read issue, so backpressure never drops or duplicates a word.
// Ports:
//   clk_i, reset_i                : clock and synchronous active-high reset
//   cmd_valid_i / cmd_ready_o     : command handshake (ready only in IDLE)
//   cmd_addr_i, cmd_len_i, cmd_dir_i : start address, word count, 0=inc 1=dec
//   out_valid_o / out_ready_i     : output word handshake
//   out_data_o, out_last_o        : ROM word and final-word flag
//   done_o                        : one-cycle pulse when the burst has drained
import rom_stream_pkg::*;

module rom_stream_reader #(
    parameter int unsigned           ADDR_WIDTH   = 12,
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter int unsigned           LEN_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = {DATA_WIDTH{DEFAULT_FILL}}
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  cmd_dir_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  done_o
);

    localparam int unsigned CNT_WIDTH = 2;

    // Control and burst registers
    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   remain_q;
    logic                   dir_q;

    // One read may be in flight inside rom_sync at a time
    logic                   inflight_q;
    logic                   inflight_last_q;
    logic [DATA_WIDTH-1:0]  rom_data;

    // Output buffer
    logic [DATA_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_last_q, fifo_last_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    // Registered outputs
    logic                   cmd_ready_q;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_last_q;
    logic                   done_q;

    logic                   pop_c;
    logic                   push_c;
    logic [CNT_WIDTH-1:0]   occupancy_c;
    logic                   credit_ok_c;
    logic                   issue_c;
    logic                   last_issue_c;

    // Credit: buffered words plus the in-flight read must fit in the buffer,
    // counting a word popped this cycle as already gone
    assign pop_c        = out_valid_q & out_ready_i;
    assign push_c       = inflight_q;
    assign occupancy_c  = count_q + CNT_WIDTH'(inflight_q);
    assign credit_ok_c  = (occupancy_c < CNT_WIDTH'(FIFO_DEPTH)) ||
                          ((occupancy_c == CNT_WIDTH'(FIFO_DEPTH)) && pop_c);
    assign issue_c      = (state_q == ST_ISSUE) && credit_ok_c;
    assign last_issue_c = issue_c && (remain_q == LEN_WIDTH'(1));

    rom_sync #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .DEFAULT_DATA (DEFAULT_DATA)
    ) u_rom (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (issue_c),
        .addr_i  (addr_q),
        .data_o  (rom_data)
    );

    // Buffer next state: returning ROM word is pushed, accepted head is popped
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_c) begin
            fifo_data_d[wr_ptr_q] = rom_data;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + CNT_WIDTH'(push_c) - CNT_WIDTH'(pop_c);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            remain_q        <= '0;
            dir_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
            cmd_ready_q     <= 1'b1;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_last_q      <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            inflight_q      <= issue_c;
            inflight_last_q <= last_issue_c;

            // Output register shows the head of the next buffer state
            out_valid_q     <= (count_d != '0);
            out_data_q      <= fifo_data_d[rd_ptr_d];
            out_last_q      <= (count_d != '0) && fifo_last_d[rd_ptr_d];
            done_q          <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        addr_q      <= cmd_addr_i;
                        remain_q    <= cmd_len_i;
                        dir_q       <= cmd_dir_i;
                        cmd_ready_q <= 1'b0;
                        state_q     <= (cmd_len_i != '0) ? ST_ISSUE : ST_DRAIN;
                    end
                end
                ST_ISSUE: begin
                    if (issue_c) begin
                        addr_q   <= dir_q ? (addr_q - ADDR_WIDTH'(1))
                                          : (addr_q + ADDR_WIDTH'(1));
                        remain_q <= remain_q - LEN_WIDTH'(1);
                        if (last_issue_c) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((count_q == '0) && !inflight_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign done_o      = done_q;

endmodule
